track_input_scheduler: RTL and testbench

- Sequences the inputs of the playfield background renderer: debounces six track keys, grants one of them to the renderer's single highlight slot (key_state/key_ascii), and schedules judgement feedback (msg) with a frame-counted hold.
- All outputs change only on a frame_start strobe, so the renderer never sees a mid-frame change.
- Sits between the key input logic / judge logic and the background renderer.

---
 rtl/track_input_scheduler_if.sv | 22 ++
 rtl/track_input_scheduler.sv | 153 +++++++++++++++
 tb/tb_track_input_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/track_input_scheduler_if.sv
// Signal bundle between the key/judge logic and the background renderer.
// The master drives the raw keys, frame strobe and judgements; the scheduler is the slave.
interface track_input_scheduler_if;
  logic [5:0] key_raw;
  logic       frame_start;
  logic       judge_valid;
  logic [1:0] judge_result;
  logic       key_state;
  logic [3:0] key_ascii;
  logic [2:0] msg;
  logic [5:0] key_pressed;

  modport master (
    output key_raw, frame_start, judge_valid, judge_result,
    input  key_state, key_ascii, msg, key_pressed
  );

  modport slave (
    input  key_raw, frame_start, judge_valid, judge_result,
    output key_state, key_ascii, msg, key_pressed
  );
endinterface

// File: rtl/track_input_scheduler.sv
// Debounces six track keys, grants one of them to the renderer's highlight slot,
// and holds judgement feedback for a fixed number of frames. Outputs move only on frame_start.
module track_input_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_FRAMES     = 30
) (
  input logic OriginalClk,
  input logic Reset,
  track_input_scheduler_if.slave bus
);

  typedef enum logic {ARB_NONE, ARB_GRANTED} arb_state_t;
  typedef enum logic {MSG_IDLE, MSG_SHOW} msg_state_t;

  localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [19:0]   DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);

  logic [5:0]  key_meta, key_sync, key_pressed;
  logic [19:0] db_cnt [6];

  arb_state_t arb_state, arb_next;
  logic [2:0] rr_ptr, rr_next, grant_idx, grant_next;
  logic [2:0] search_idx, cand;
  logic       search_hit;
  logic       key_state, key_state_next;
  logic [3:0] key_ascii, key_ascii_next;

  msg_state_t    msg_state, msg_state_next;
  logic [1:0]    pending_res, pending_res_next;
  logic          pending_valid, pending_valid_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [2:0]    msg, msg_next;

  // A key flips only after its synchronized level has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge OriginalClk or posedge Reset) begin
    if (Reset) begin
      key_meta    <= '0;
      key_sync    <= '0;
      key_pressed <= '0;
      for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
    end else begin
      key_meta <= bus.key_raw;
      key_sync <= key_meta;
      for (int i = 0; i < 6; i++) begin
        if (key_sync[i] == key_pressed[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= DB_LAST) begin
          key_pressed[i] <= ~key_pressed[i];
          db_cnt[i]      <= '0;
        end else if (db_cnt[i] != '1) begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  // Round-robin search: first pressed key strictly after rr_ptr, wrapping modulo 6.
  always_comb begin
    search_hit = 1'b0;
    search_idx = rr_ptr;
    cand       = '0;
    for (int k = 1; k <= 6; k++) begin
      cand = 3'((int'(rr_ptr) + k) % 6);
      if (!search_hit && key_pressed[cand]) begin
        search_hit = 1'b1;
        search_idx = cand;
      end
    end
  end

  always_comb begin
    arb_next       = arb_state;
    grant_next     = grant_idx;
    rr_next        = rr_ptr;
    key_state_next = key_state;
    key_ascii_next = key_ascii;
    if (bus.frame_start && !(arb_state == ARB_GRANTED && key_pressed[grant_idx])) begin
      if (search_hit) begin
        arb_next       = ARB_GRANTED;
        grant_next     = search_idx;
        rr_next        = search_idx;
        key_state_next = 1'b1;
        key_ascii_next = {1'b0, search_idx} + 4'd1;
      end else begin
        arb_next       = ARB_NONE;
        key_state_next = 1'b0;
        key_ascii_next = '0;
      end
    end
  end

  // A judgement arriving with frame_start lands in pending and waits for the next strobe.
  always_comb begin
    msg_state_next     = msg_state;
    pending_res_next   = pending_res;
    pending_valid_next = pending_valid;
    hold_next          = hold_cnt;
    msg_next           = msg;
    if (bus.frame_start) begin
      if (pending_valid) begin
        msg_next           = {1'b0, pending_res};
        hold_next          = HOLD_LOAD;
        pending_valid_next = 1'b0;
        msg_state_next     = MSG_SHOW;
      end else if (msg_state == MSG_SHOW) begin
        if (hold_cnt <= HW'(1)) begin
          hold_next      = '0;
          msg_next       = '0;
          msg_state_next = MSG_IDLE;
        end else begin
          hold_next = hold_cnt - HW'(1);
        end
      end
    end
    if (bus.judge_valid && bus.judge_result != 2'd0) begin
      pending_valid_next = 1'b1;
      pending_res_next   = bus.judge_result;
    end
  end

  always_ff @(posedge OriginalClk or posedge Reset) begin
    if (Reset) begin
      arb_state     <= ARB_NONE;
      grant_idx     <= '0;
      rr_ptr        <= 3'd5;
      key_state     <= 1'b0;
      key_ascii     <= '0;
      msg_state     <= MSG_IDLE;
      pending_res   <= '0;
      pending_valid <= 1'b0;
      hold_cnt      <= '0;
      msg           <= '0;
    end else begin
      arb_state     <= arb_next;
      grant_idx     <= grant_next;
      rr_ptr        <= rr_next;
      key_state     <= key_state_next;
      key_ascii     <= key_ascii_next;
      msg_state     <= msg_state_next;
      pending_res   <= pending_res_next;
      pending_valid <= pending_valid_next;
      hold_cnt      <= hold_next;
      msg           <= msg_next;
    end
  end

  assign bus.key_state   = key_state;
  assign bus.key_ascii   = key_ascii;
  assign bus.msg         = msg;
  assign bus.key_pressed = key_pressed;

endmodule

// File: tb/tb_track_input_scheduler.sv
// Self-checking bench for track_input_scheduler: directed table, hand-written corner
// sequences and randomized traffic, all compared against a behavioural model.
module tb_track_input_scheduler;

  localparam int DB    = 4;
  localparam int HOLD  = 3;
  localparam int FRAME = 20;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  track_input_scheduler_if bus();

  track_input_scheduler #(.DEBOUNCE_CYCLES(DB), .HOLD_FRAMES(HOLD)) dut (
    .OriginalClk(clk),
    .Reset(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] raw;
    bit         jv;
    logic [1:0] jres;
    int         frames;
    logic [3:0] exp_ascii;
    logic [2:0] exp_msg;
  } step_t;

  // Behavioural model: tracks how long each synchronized key has disagreed, the
  // granted track number (0 = none), and how many frames a judgement has left.
  logic [5:0] m_hist1, m_hist2, m_pressed;
  int m_run [6];
  int m_grant, m_last, m_left, m_pending, m_msg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist1 = '0; m_hist2 = '0; m_pressed = '0;
      for (int i = 0; i < 6; i++) m_run[i] = 0;
      m_grant = 0; m_last = 5; m_left = 0; m_pending = -1; m_msg = 0;
    end else begin
      if (bus.frame_start) begin
        if (!(m_grant != 0 && m_pressed[m_grant-1])) begin
          m_grant = 0;
          for (int k = 1; k <= 6; k++) begin
            if (m_grant == 0 && m_pressed[(m_last + k) % 6]) begin
              m_grant = (m_last + k) % 6 + 1;
            end
          end
          if (m_grant != 0) m_last = m_grant - 1;
        end
        if (m_pending >= 0) begin
          m_msg = m_pending; m_left = HOLD; m_pending = -1;
        end else if (m_left > 0) begin
          m_left = m_left - 1;
          if (m_left == 0) m_msg = 0;
        end
      end
      if (bus.judge_valid && bus.judge_result != 0) m_pending = int'(bus.judge_result);
      for (int i = 0; i < 6; i++) begin
        if (m_hist2[i] == m_pressed[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= DB) begin
          m_pressed[i] = ~m_pressed[i];
          m_run[i] = 0;
        end else m_run[i] = m_run[i] + 1;
      end
      m_hist2 = m_hist1;
      m_hist1 = bus.key_raw;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One clock: compare against the model at the falling edge, then set up the next inputs.
  task automatic tick();
    @(negedge clk);
    checkOutput("model", {2'b0, bus.key_state, bus.key_ascii, bus.msg, bus.key_pressed},
                {2'b0, m_grant != 0, 4'(m_grant), 3'(m_msg), m_pressed});
    cyc++;
    bus.frame_start  = (cyc % FRAME == 0);
    bus.judge_valid  = 1'b0;
    bus.judge_result = 2'd0;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      while (!bus.frame_start) tick();
      tick();
    end
  endtask

  task automatic judge(input logic [1:0] res);
    bus.judge_valid  = 1'b1;
    bus.judge_result = res;
    tick();
  endtask

  task automatic applyStimulus(input step_t s, input int idx);
    bus.key_raw = s.raw;
    if (s.jv) judge(s.jres);
    wait_frames(s.frames);
    checkOutput($sformatf("step%0d_ascii", idx), 16'(bus.key_ascii), 16'(s.exp_ascii));
    checkOutput($sformatf("step%0d_msg", idx), 16'(bus.msg), 16'(s.exp_msg));
  endtask

  step_t steps [16];
  int hold_left;

  initial begin
    steps[0]  = '{6'b000010, 0, 2'd0, 2, 4'd2, 3'd0};
    steps[1]  = '{6'b010010, 0, 2'd0, 2, 4'd2, 3'd0};
    steps[2]  = '{6'b010000, 0, 2'd0, 2, 4'd5, 3'd0};
    steps[3]  = '{6'b100001, 0, 2'd0, 2, 4'd6, 3'd0};
    steps[4]  = '{6'b100001, 1, 2'd3, 1, 4'd6, 3'd3};
    steps[5]  = '{6'b100001, 0, 2'd0, 1, 4'd6, 3'd3};
    steps[6]  = '{6'b100001, 0, 2'd0, 1, 4'd6, 3'd3};
    steps[7]  = '{6'b100001, 0, 2'd0, 1, 4'd6, 3'd0};
    steps[8]  = '{6'b100001, 1, 2'd2, 1, 4'd6, 3'd2};
    steps[9]  = '{6'b100001, 1, 2'd0, 1, 4'd6, 3'd2};
    steps[10] = '{6'b100001, 0, 2'd0, 1, 4'd6, 3'd2};
    steps[11] = '{6'b100001, 1, 2'd1, 1, 4'd6, 3'd1};
    steps[12] = '{6'b100001, 0, 2'd0, 1, 4'd6, 3'd1};
    steps[13] = '{6'b100001, 0, 2'd0, 1, 4'd6, 3'd1};
    steps[14] = '{6'b100001, 0, 2'd0, 1, 4'd6, 3'd0};
    steps[15] = '{6'b000000, 0, 2'd0, 2, 4'd0, 3'd0};

    clk = 1'b0;
    rst = 1'b1;
    bus.key_raw = '0; bus.frame_start = 1'b0; bus.judge_valid = 1'b0; bus.judge_result = '0;
    tick(); tick();
    checkOutput("reset_outputs", {2'b0, bus.key_state, bus.key_ascii, bus.msg, bus.key_pressed}, 16'd0);
    rst = 1'b0;
    tick(); tick();

    // Debounce: a 3-cycle glitch is rejected, a stable press lands exactly 2+DB cycles later.
    bus.key_raw = 6'b000001;
    tick(); tick(); tick();
    bus.key_raw = 6'b000000;
    repeat (10) tick();
    checkOutput("glitch_rejected", 16'(bus.key_pressed), 16'd0);
    bus.key_raw = 6'b100001;
    repeat (5) tick();
    checkOutput("debounce_early", 16'(bus.key_pressed), 16'd0);
    tick();
    checkOutput("debounce_exact", 16'(bus.key_pressed), 16'b100001);
    wait_frames(1);
    checkOutput("first_grant_state", 16'(bus.key_state), 16'd1);
    checkOutput("first_grant_ascii", 16'(bus.key_ascii), 16'd1);
    bus.key_raw = 6'b000000;
    wait_frames(2);
    checkOutput("release_all", 16'(bus.key_ascii), 16'd0);

    for (int i = 0; i < 16; i++) applyStimulus(steps[i], i);

    // Reset mid-grant and mid-hold clears outputs immediately; re-grant waits for a frame.
    bus.key_raw = 6'b000100;
    judge(2'd3);
    wait_frames(2);
    checkOutput("pre_reset_ascii", 16'(bus.key_ascii), 16'd3);
    checkOutput("pre_reset_msg", 16'(bus.msg), 16'd3);
    rst = 1'b1;
    #1;
    checkOutput("async_reset", {2'b0, bus.key_state, bus.key_ascii, bus.msg, bus.key_pressed}, 16'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    checkOutput("post_reset_ascii", 16'(bus.key_ascii), 16'd0);
    wait_frames(2);
    checkOutput("regrant_ascii", 16'(bus.key_ascii), 16'd3);

    // Overwrite: two judgements before one strobe, the later one wins.
    judge(2'd1);
    judge(2'd2);
    wait_frames(1);
    checkOutput("overwrite_msg", 16'(bus.msg), 16'd2);
    wait_frames(4);
    checkOutput("hold_expired", 16'(bus.msg), 16'd0);

    // Judgement coinciding with frame_start shows only at the following strobe.
    while (!bus.frame_start) tick();
    judge(2'd2);
    checkOutput("simul_same_strobe", 16'(bus.msg), 16'd0);
    wait_frames(1);
    checkOutput("simul_next_strobe", 16'(bus.msg), 16'd2);

    hold_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold_left == 0) begin
        bus.key_raw = 6'($urandom);
        hold_left = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 60);
      end
      hold_left--;
      if ($urandom_range(0, 9) == 0) begin
        bus.judge_valid  = 1'b1;
        bus.judge_result = 2'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
